// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline stages, the byte-wide RAM and mem_arbiter.
// The slave side is the arbiter. The master side is the pipeline/RAM environment.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  flush;
   logic                  if_done;
   logic [31:0]           if_data;

   logic                  mem_req;
   logic                  mem_we;
   logic [1:0]            mem_len;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic                  mem_done;
   logic [31:0]           mem_rdata;

   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_wr;
   logic [7:0]            ram_dout;
   logic [7:0]            ram_din;

   logic                  busy;

   modport slave (
      input  if_req, if_addr, flush,
      output if_done, if_data,
      input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
      output mem_done, mem_rdata,
      output ram_addr, ram_wr, ram_dout,
      input  ram_din,
      output busy
   );

   modport master (
      output if_req, if_addr, flush,
      input  if_done, if_data,
      output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
      input  mem_done, mem_rdata,
      input  ram_addr, ram_wr, ram_dout,
      output ram_din,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store.
// Accesses are sequenced one byte per cycle and packed little-endian. MEM has priority over IF.
module mem_arbiter #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR  = '0
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] base;
   logic [2:0]            len_n;
   logic [2:0]            cyc;
   logic                  is_mem;
   logic [31:0]           wdata;
   logic [31:0]           asm_data;
   logic [31:0]           asm_next;
   logic [ADDR_WIDTH-1:0] next_addr;

   function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
      case (k)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

   // The byte arriving in cycle c belongs to the address driven in cycle c-1, so it fills byte c-2.
   always_comb begin
      asm_next = asm_data;
      case (cyc)
         3'd2:    asm_next[7:0]   = bus.ram_din;
         3'd3:    asm_next[15:8]  = bus.ram_din;
         3'd4:    asm_next[23:16] = bus.ram_din;
         3'd5:    asm_next[31:24] = bus.ram_din;
         default: asm_next        = asm_data;
      endcase
   end

   assign next_addr = base + ADDR_WIDTH'(cyc);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         base          <= '0;
         len_n         <= '0;
         cyc           <= '0;
         is_mem        <= 1'b0;
         wdata         <= '0;
         asm_data      <= '0;
         bus.ram_addr  <= IDLE_ADDR;
         bus.ram_wr    <= 1'b0;
         bus.ram_dout  <= '0;
         bus.if_done   <= 1'b0;
         bus.if_data   <= '0;
         bus.mem_done  <= 1'b0;
         bus.mem_rdata <= '0;
         bus.busy      <= 1'b0;
      end else begin
         bus.if_done  <= 1'b0;
         bus.mem_done <= 1'b0;
         case (state)
            IDLE: begin
               cyc      <= 3'd1;
               asm_data <= '0;
               if (bus.mem_req) begin
                  is_mem       <= 1'b1;
                  base         <= bus.mem_addr;
                  wdata        <= bus.mem_wdata;
                  len_n        <= (bus.mem_len == 2'b00) ? 3'd1 :
                                  (bus.mem_len == 2'b01) ? 3'd2 : 3'd4;
                  bus.ram_addr <= bus.mem_addr;
                  bus.busy     <= 1'b1;
                  if (bus.mem_we) begin
                     state        <= WR;
                     bus.ram_wr   <= 1'b1;
                     bus.ram_dout <= bus.mem_wdata[7:0];
                  end else begin
                     state <= RD;
                  end
               end else if (bus.if_req && !bus.flush) begin
                  is_mem       <= 1'b0;
                  base         <= bus.if_addr;
                  len_n        <= 3'd4;
                  bus.ram_addr <= bus.if_addr;
                  bus.busy     <= 1'b1;
                  state        <= RD;
               end
            end

            // A redirect kills only a fetch; loads run to completion regardless of flush.
            RD: begin
               if (!is_mem && bus.flush) begin
                  state        <= IDLE;
                  bus.ram_addr <= IDLE_ADDR;
                  bus.busy     <= 1'b0;
               end else begin
                  asm_data     <= asm_next;
                  cyc          <= cyc + 3'd1;
                  bus.ram_addr <= (cyc < len_n) ? next_addr : IDLE_ADDR;
                  if (cyc == len_n + 3'd1) begin
                     state <= DONE;
                     if (is_mem) begin
                        bus.mem_rdata <= asm_next;
                        bus.mem_done  <= 1'b1;
                     end else begin
                        bus.if_data <= asm_next;
                        bus.if_done <= 1'b1;
                     end
                  end
               end
            end

            WR: begin
               if (cyc < len_n) begin
                  bus.ram_addr <= next_addr;
                  bus.ram_dout <= pick_byte(wdata, cyc[1:0]);
                  cyc          <= cyc + 3'd1;
               end else begin
                  bus.ram_wr   <= 1'b0;
                  bus.ram_addr <= IDLE_ADDR;
                  bus.mem_done <= 1'b1;
                  state        <= DONE;
               end
            end

            DONE: begin
               bus.ram_addr <= IDLE_ADDR;
               bus.busy     <= 1'b0;
               state        <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule
